psl_bw_assembler: RTL and testbench

AFU-side consumer of the PSL buffer-write interface. Captures the two consecutive 512-bit halves (`ha_bwad` = 0, then 1) of each 128-byte buffer-write transfer and checks tag and data parity. Reassembles each transfer into one 1024-bit line and hands complete lines to the AFU datapath through a small line FIFO with a valid/ready handshake.

---
 rtl/psl_bw_assembler.sv | 165 ++++++++++++++++
 tb/tb_psl_bw_assembler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psl_bw_assembler.sv
// psl_bw_assembler: PSL buffer-write consumer. Pairs the two 512-bit halves
// (ha_bwad 0 then 1, consecutive cycles) of each 128-byte transfer into one
// 1024-bit line and queues complete lines in a DEPTH-entry FIFO with a
// valid/ready head. Sequence errors pulse err_seq; full-FIFO drops set
// err_overflow and bump drop_count.
// Optional feature: define PSL_BW_PARITY_CHECK_EN to enable tag/data odd
// parity checking (err_tagpar, err_datapar, line_perr); otherwise those
// outputs are tied to 0 and the parity inputs are ignored.
module psl_bw_assembler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           ha_pclock,
  input  logic           ha_reset,
  input  logic           ha_bwvalid,
  input  logic [0:7]     ha_bwtag,
  input  logic           ha_bwtagpar,
  input  logic [0:5]     ha_bwad,
  input  logic [0:511]   ha_bwdata,
  input  logic [0:7]     ha_bwpar,
  output logic           line_valid,
  input  logic           line_ready,
  output logic [0:7]     line_tag,
  output logic [0:1023]  line_data,
  output logic           line_perr,
  output logic           err_tagpar,
  output logic           err_datapar,
  output logic           err_seq,
  output logic           err_overflow,
  output logic [7:0]     drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, HAVE_H0} state_t;

  state_t          state;
  logic [0:7]      h0_tag;
  logic [0:511]    h0_data;
  logic            beat0, beat1;
  logic            latch_h0, push, seq_err;

  logic [0:1023]   data_mem [DEPTH];
  logic [0:7]      tag_mem  [DEPTH];
  logic [AW:0]     wptr, rptr;
  logic [AW-1:0]   waddr, raddr;
  logic            full, empty, pop, push_ok;

  assign beat0 = ha_bwvalid && (ha_bwad == 6'd0);
  assign beat1 = ha_bwvalid && (ha_bwad == 6'd1);

  // Beat decode: decide whether to latch half 0, complete a line, or flag a sequence error
  always_comb begin
    latch_h0 = 1'b0;
    push     = 1'b0;
    seq_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (beat0)           latch_h0 = 1'b1;
        else if (ha_bwvalid) seq_err  = 1'b1;
      end
      HAVE_H0: begin
        if (beat1 && (ha_bwtag == h0_tag)) begin
          push = 1'b1;
        end else begin
          // every other case (no beat, wrong tag, repeated half 0, bad address)
          // is a sequence error; only a fresh half 0 restarts the pair
          seq_err  = 1'b1;
          latch_h0 = beat0;
        end
      end
    endcase
  end

  // Assembler state, captured half-0 tag and the registered sequence-error pulse
  always_ff @(posedge ha_pclock) begin
    if (ha_reset) begin
      state   <= IDLE;
      h0_tag  <= '0;
      err_seq <= 1'b0;
    end else begin
      state   <= latch_h0 ? HAVE_H0 : IDLE;
      err_seq <= seq_err;
      if (latch_h0) h0_tag <= ha_bwtag;
    end
  end

  assign waddr   = wptr[AW-1:0];
  assign raddr   = rptr[AW-1:0];
  assign empty   = (wptr == rptr);
  assign full    = (waddr == raddr) && (wptr[AW] != rptr[AW]);
  assign pop     = line_valid && line_ready;
  assign push_ok = push && (!full || pop);

  // FIFO pointers, overflow flag and saturating drop counter
  always_ff @(posedge ha_pclock) begin
    if (ha_reset) begin
      wptr         <= '0;
      rptr         <= '0;
      err_overflow <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (pop)     rptr <= rptr + {{AW{1'b0}}, 1'b1};
      if (push_ok) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (push && !push_ok) begin
        err_overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Datapath storage: half-0 data and FIFO line payloads (no reset needed)
  always_ff @(posedge ha_pclock) begin
    if (latch_h0) h0_data <= ha_bwdata;
    if (push_ok) begin
      data_mem[waddr] <= {h0_data, ha_bwdata};
      tag_mem[waddr]  <= h0_tag;
    end
  end

  // Head outputs are masked while empty so stale storage never shows
  assign line_valid = !empty;
  assign line_tag   = line_valid ? tag_mem[raddr]  : '0;
  assign line_data  = line_valid ? data_mem[raddr] : '0;

`ifdef PSL_BW_PARITY_CHECK_EN
  logic tag_bad, data_bad, beat_perr, h0_perr;
  logic perr_mem [DEPTH];

  // Odd-parity check of the tag and each 64-bit dword of the current beat
  always_comb begin
    tag_bad  = ~^{ha_bwtag, ha_bwtagpar};
    data_bad = 1'b0;
    for (int unsigned k = 0; k < 8; k++)
      data_bad = data_bad | ~^{ha_bwdata[64*k +: 64], ha_bwpar[k]};
    beat_perr = ha_bwvalid && (tag_bad || data_bad);
  end

  // Parity error pulses and the half-0 error carried into the line
  always_ff @(posedge ha_pclock) begin
    if (ha_reset) begin
      err_tagpar  <= 1'b0;
      err_datapar <= 1'b0;
      h0_perr     <= 1'b0;
    end else begin
      err_tagpar  <= ha_bwvalid && tag_bad;
      err_datapar <= ha_bwvalid && data_bad;
      if (latch_h0) h0_perr <= beat_perr;
    end
  end

  // Per-entry parity flag stored alongside the line payload
  always_ff @(posedge ha_pclock) begin
    if (push_ok) perr_mem[waddr] <= h0_perr || beat_perr;
  end

  assign line_perr = line_valid && perr_mem[raddr];
`else
  logic unused_par;
  assign unused_par  = ^{ha_bwtagpar, ha_bwpar};
  assign err_tagpar  = 1'b0;
  assign err_datapar = 1'b0;
  assign line_perr   = 1'b0;
`endif

endmodule

// File: tb/tb_psl_bw_assembler.sv
// Testbench for psl_bw_assembler: directed vector table, hand-written FIFO
// and reset sequences, then randomized traffic against a queue-based model.
module tb_psl_bw_assembler;

  localparam int unsigned DEPTH = 4;
`ifdef PSL_BW_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk;
  logic          ha_reset, ha_bwvalid, ha_bwtagpar, line_ready;
  logic [0:7]    ha_bwtag, ha_bwpar, line_tag;
  logic [0:5]    ha_bwad;
  logic [0:511]  ha_bwdata;
  logic          line_valid, line_perr, err_tagpar, err_datapar, err_seq, err_overflow;
  logic [0:1023] line_data;
  logic [7:0]    drop_count;

  psl_bw_assembler #(.DEPTH(DEPTH)) dut (
    .ha_pclock(clk), .ha_reset(ha_reset), .ha_bwvalid(ha_bwvalid),
    .ha_bwtag(ha_bwtag), .ha_bwtagpar(ha_bwtagpar), .ha_bwad(ha_bwad),
    .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar), .line_valid(line_valid),
    .line_ready(line_ready), .line_tag(line_tag), .line_data(line_data),
    .line_perr(line_perr), .err_tagpar(err_tagpar), .err_datapar(err_datapar),
    .err_seq(err_seq), .err_overflow(err_overflow), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [0:1023] act, input logic [0:1023] exp);
    bit shown;
    checks++;
    if (act !== exp) begin
      errors++;
      shown = 1'b0;
      for (int k = 0; k < 16; k++)
        if (!shown && act[64*k +: 64] !== exp[64*k +: 64]) begin
          shown = 1'b1;
          $display("FAIL %s: dword %0d got %h expected %h (t=%0t)", name, k,
                   act[64*k +: 64], exp[64*k +: 64], $time);
        end
    end
  endtask

  task automatic drive(input bit rst, input bit v, input logic [0:7] tag, input bit tbad,
                       input logic [0:5] ad, input logic [0:511] d, input logic [0:7] pflip,
                       input bit rdy);
    logic [0:7] p;
    for (int k = 0; k < 8; k++) p[k] = (~^d[64*k +: 64]) ^ pflip[k];
    ha_reset    = rst;
    ha_bwvalid  = v;
    ha_bwtag    = tag;
    ha_bwtagpar = (~^tag) ^ tbad;
    ha_bwad     = ad;
    ha_bwdata   = d;
    ha_bwpar    = p;
    line_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst, input bit rdy);
    drive(rst, 1'b0, 8'h00, 1'b0, 6'd0, '0, 8'h00, rdy);
    tick();
  endtask

  task automatic send_pair(input logic [7:0] tag, input logic [7:0] f, input bit rdy);
    drive(1'b0, 1'b1, tag, 1'b0, 6'd0, {64{f}}, 8'h00, rdy);
    tick();
    drive(1'b0, 1'b1, tag, 1'b0, 6'd1, {64{~f}}, 8'h00, rdy);
    tick();
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [0:7]    tag;
    logic [0:1023] data;
    bit            perr;
  } line_t;

  line_t        mq[$];
  bit           m_have, m_h0perr, m_ovf, m_etag, m_edata, m_eseq;
  logic [0:7]   m_tag;
  logic [0:511] m_data;
  logic [7:0]   m_drops;

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit pop, push, seq, terr, derr, bperr;
    line_t ln;
    if (ha_reset) begin
      mq.delete();
      m_have = 0; m_ovf = 0; m_drops = 0; m_etag = 0; m_edata = 0; m_eseq = 0;
      return;
    end
    pop  = (mq.size() > 0) && line_ready;
    terr = PEN && ha_bwvalid && ($countones({ha_bwtag, ha_bwtagpar}) % 2 == 0);
    derr = 1'b0;
    for (int k = 0; k < 8; k++)
      if ($countones({ha_bwdata[64*k +: 64], ha_bwpar[k]}) % 2 == 0) derr = PEN && ha_bwvalid;
    bperr = terr || derr;
    seq = 0; push = 0;
    if (m_have) begin
      if (ha_bwvalid && ha_bwad == 6'd1 && ha_bwtag == m_tag) begin
        push = 1; ln.tag = m_tag; ln.data = {m_data, ha_bwdata}; ln.perr = m_h0perr || bperr;
        m_have = 0;
      end else if (ha_bwvalid && ha_bwad == 6'd0) begin
        seq = 1; m_tag = ha_bwtag; m_data = ha_bwdata; m_h0perr = bperr;
      end else begin
        seq = 1; m_have = 0;
      end
    end else if (ha_bwvalid && ha_bwad == 6'd0) begin
      m_have = 1; m_tag = ha_bwtag; m_data = ha_bwdata; m_h0perr = bperr;
    end else if (ha_bwvalid) begin
      seq = 1;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(ln);
      else begin
        m_ovf = 1;
        if (m_drops != 8'hFF) m_drops++;
      end
    end
    m_etag = terr; m_edata = derr; m_eseq = seq;
  endtask

  task automatic check_model();
    bit ev;
    ev = mq.size() > 0;
    chk("m_line_valid", line_valid, ev);
    chk("m_line_tag", line_tag, ev ? mq[0].tag : 8'h00);
    chk_data("m_line_data", line_data, ev ? mq[0].data : '0);
    chk("m_line_perr", line_perr, ev ? mq[0].perr : 1'b0);
    chk("m_err_tagpar", err_tagpar, m_etag);
    chk("m_err_datapar", err_datapar, m_edata);
    chk("m_err_seq", err_seq, m_eseq);
    chk("m_err_overflow", err_overflow, m_ovf);
    chk("m_drop_count", drop_count, m_drops);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         v;
    logic [7:0] tag;
    bit         tbad;
    logic [5:0] ad;
    logic [7:0] fill;
    logic [7:0] pflip;
    bit         ev;
    logic [7:0] etag, ef0, ef1;
    bit         eperr, eseq, etagp, edatp;
  } vec_t;

  function automatic vec_t mk(bit v, logic [7:0] tag, bit tbad, logic [5:0] ad, logic [7:0] fill,
                              logic [7:0] pflip, bit ev, logic [7:0] etag, logic [7:0] ef0,
                              logic [7:0] ef1, bit eperr, bit eseq, bit etagp, bit edatp);
    vec_t t;
    t.v = v; t.tag = tag; t.tbad = tbad; t.ad = ad; t.fill = fill; t.pflip = pflip;
    t.ev = ev; t.etag = etag; t.ef0 = ef0; t.ef1 = ef1;
    t.eperr = eperr; t.eseq = eseq; t.etagp = etagp; t.edatp = edatp;
    return t;
  endfunction

  initial begin
    vec_t          tbl[$];
    logic [0:1023] ed;
    bit            g_have, rst, v, tbad, rdy;
    logic [7:0]    g_tag, tag, pflip;
    logic [5:0]    ad;
    logic [0:511]  d;
    int unsigned   r, phase;

    //          v  tag    tb ad  fill   pflip | ev etag   ef0    ef1    perr seq tagp datp
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h05, 0, 0, 8'hA5, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h05, 0, 1, 8'h5A, 8'h00, 1, 8'h05, 8'hA5, 8'h5A, 0,   0, 0,   0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h10, 0, 0, 8'hA5, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h11, 0, 1, 8'h5A, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   1, 0,   0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h20, 0, 0, 8'h11, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h20, 0, 1, 8'h22, 8'h00, 1, 8'h20, 8'h11, 8'h22, 0,   0, 0,   0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h30, 0, 0, 8'h33, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h30, 0, 1, 8'h44, 8'h10, 1, 8'h30, 8'h33, 8'h44, PEN, 0, 0,   PEN));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h40, 0, 1, 8'h55, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   1, 0,   0));
    tbl.push_back(mk(1, 8'h40, 0, 0, 8'h55, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   1, 0,   0));
    tbl.push_back(mk(1, 8'h41, 0, 5, 8'h66, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   1, 0,   0));
    tbl.push_back(mk(1, 8'h50, 1, 0, 8'h77, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, PEN, 0));
    tbl.push_back(mk(1, 8'h50, 0, 1, 8'h88, 8'h00, 1, 8'h50, 8'h77, 8'h88, PEN, 0, 0,   0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h60, 0, 0, 8'h99, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h61, 0, 0, 8'hAA, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   1, 0,   0));
    tbl.push_back(mk(1, 8'h61, 0, 1, 8'hBB, 8'h00, 1, 8'h61, 8'hAA, 8'hBB, 0,   0, 0,   0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));
    tbl.push_back(mk(1, 8'h70, 1, 1, 8'hCC, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   1, PEN, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0,   0, 0,   0));

    // reset state
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_line_tag", line_tag, 8'h00);
    chk_data("rst_line_data", line_data, '0);
    chk("rst_err_seq", err_seq, 1'b0);
    chk("rst_err_overflow", err_overflow, 1'b0);
    chk("rst_drop_count", drop_count, 8'h00);

    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].v, tbl[i].tag, tbl[i].tbad, tbl[i].ad, {64{tbl[i].fill}}, tbl[i].pflip, 1'b1);
      tick();
      ed = tbl[i].ev ? {{64{tbl[i].ef0}}, {64{tbl[i].ef1}}} : '0;
      chk($sformatf("v%0d_line_valid", i), line_valid, tbl[i].ev);
      chk($sformatf("v%0d_line_tag", i), line_tag, tbl[i].etag);
      chk_data($sformatf("v%0d_line_data", i), line_data, ed);
      chk($sformatf("v%0d_line_perr", i), line_perr, tbl[i].eperr);
      chk($sformatf("v%0d_err_seq", i), err_seq, tbl[i].eseq);
      chk($sformatf("v%0d_err_tagpar", i), err_tagpar, tbl[i].etagp);
      chk($sformatf("v%0d_err_datapar", i), err_datapar, tbl[i].edatp);
      chk($sformatf("v%0d_drop_count", i), drop_count, 8'h00);
    end

    // overflow: DEPTH+2 lines with no consumer, then drain in order
    idle(1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) send_pair(8'(8'h80 + i), 8'(i), 1'b0);
    idle(1'b0, 1'b0);
    chk("ovf_drop_count", drop_count, 8'd2);
    chk("ovf_err_overflow", err_overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_valid%0d", i), line_valid, 1'b1);
      chk($sformatf("ovf_tag%0d", i), line_tag, 8'(8'h80 + i));
      chk_data($sformatf("ovf_data%0d", i), line_data, {{64{8'(i)}}, {64{~8'(i)}}});
      idle(1'b0, 1'b1);
    end
    chk("ovf_drained", line_valid, 1'b0);
    chk("ovf_sticky", err_overflow, 1'b1);

    // full FIFO with pop on the same edge as half 1: no drop
    idle(1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) send_pair(8'(8'h90 + i), 8'(8'h40 + i), 1'b0);
    drive(1'b0, 1'b1, 8'h9F, 1'b0, 6'd0, {64{8'hE1}}, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h9F, 1'b0, 6'd1, {64{8'h1E}}, 8'h00, 1'b1);
    tick();
    chk("fullpop_drop_count", drop_count, 8'd0);
    chk("fullpop_err_overflow", err_overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fullpop_valid%0d", i), line_valid, 1'b1);
      chk($sformatf("fullpop_tag%0d", i), line_tag, (i == DEPTH - 1) ? 8'h9F : 8'(8'h91 + i));
      idle(1'b0, 1'b1);
    end
    chk("fullpop_drained", line_valid, 1'b0);

    // reset between half 0 and half 1
    idle(1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) send_pair(8'(8'hA0 + i), 8'(i), 1'b0);
    drive(1'b0, 1'b1, 8'h70, 1'b0, 6'd0, {64{8'h77}}, 8'h00, 1'b0);
    tick();
    idle(1'b1, 1'b0);
    chk("midrst_line_valid", line_valid, 1'b0);
    chk("midrst_line_tag", line_tag, 8'h00);
    chk("midrst_err_seq", err_seq, 1'b0);
    chk("midrst_drop_count", drop_count, 8'h00);
    chk("midrst_err_overflow", err_overflow, 1'b0);
    idle(1'b0, 1'b0);
    chk("midrst_err_seq_after", err_seq, 1'b0);
    chk("midrst_still_empty", line_valid, 1'b0);
    send_pair(8'h7A, 8'h3C, 1'b0);
    chk("midrst_next_valid", line_valid, 1'b1);
    chk("midrst_next_tag", line_tag, 8'h7A);
    chk("midrst_next_seq", err_seq, 1'b0);

    // randomized traffic against the model
    drive(1'b1, 1'b0, 8'h00, 1'b0, 6'd0, '0, 8'h00, 1'b0);
    model_step();
    tick();
    check_model();
    g_have = 0; g_tag = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 99);
      v = 1; ad = 0; tag = 8'($urandom_range(0, 7));
      if (g_have) begin
        if (r < 85)      begin ad = 1; tag = g_tag; end
        else if (r < 90) begin ad = 1; tag = g_tag ^ 8'h01; end
        else if (r < 95) v = 0;
      end else begin
        if (r < 60)      ad = 0;
        else if (r < 70) ad = 1;
        else if (r < 75) ad = 6'($urandom_range(2, 63));
        else             v = 0;
      end
      for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
      tbad  = ($urandom_range(0, 19) == 0);
      pflip = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      phase = (cyc / 150) % 3;
      rdy   = (phase == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 299) == 0);
      if (v && ad == 0) g_tag = tag;
      g_have = v && (ad == 0) && !rst;
      drive(rst, v, tag, tbad, ad, d, pflip, rdy);
      model_step();
      tick();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
